// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer and its helpers.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT,
    RELEASE,
    RUN,
    PASSERT
  } state_e;

  localparam int CausePor = 0;
  localparam int CausePll = 1;
  localparam int CauseBtn = 2;
  localparam int CauseSw  = 3;

endpackage

// File: rtl/rst_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for a slow asynchronous switch.
// The output flips only after the synchronised level has differed from it for Cycles consecutive cycles.
module rst_debounce #(
  parameter int Cycles = 65536
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic db_o
);

  localparam int CntW = $clog2(Cycles) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Cycles - 1);

  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any sample that matches the accepted level restarts the stability count.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CntLast) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/rst_sequencer.sv
// Ordered multi-domain reset generator: PLL lock, debounced button and masked software resets,
// ascending release with a programmable gap, and sticky reset-cause flags.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NumDomains     = 4,
  parameter int HoldCycles     = 256,
  parameter int ReleaseGap     = 16,
  parameter int DebounceCycles = 65536
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pll_locked_i,
  input  logic                  rst_btn_i,
  input  logic                  sw_rst_req_i,
  input  logic [NumDomains-1:0] sw_rst_mask_i,
  input  logic                  cause_clr_i,
  output logic [NumDomains-1:0] rst_no,
  output logic                  all_released_o,
  output logic [3:0]            rst_cause_o
);

  localparam int MaxHg = (HoldCycles > ReleaseGap) ? HoldCycles : ReleaseGap;
  localparam int MaxAll = (MaxHg > DebounceCycles) ? MaxHg : DebounceCycles;
  localparam int CntW = $clog2(MaxAll) + 1;
  localparam int IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(ReleaseGap - 1);

  logic pll_s1_q, lock_s, btn_db, full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pll_s1_q <= 1'b0;
      lock_s   <= 1'b0;
    end else begin
      pll_s1_q <= pll_locked_i;
      lock_s   <= pll_s1_q;
    end
  end

  rst_debounce #(
    .Cycles(DebounceCycles)
  ) u_btn_db (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(rst_btn_i),
    .db_o   (btn_db)
  );

  assign full = !lock_s || btn_db;

  state_e                state_q, state_d;
  logic [CntW-1:0]       hold_q, hold_d, gap_q, gap_d;
  logic [IdxW-1:0]       idx_q, idx_d, nxt;
  logic [NumDomains-1:0] mask_q, mask_d, tgt, rst_n_q, rst_n_d;
  logic                  partial_q, partial_d, all_rel_q, all_rel_d;
  logic [3:0]            cause_q, cause_d;
  logic                  found, more;

  // Outside RELEASE the search starts below index 0, so hold exit picks the first target.
  always_comb begin
    tgt   = partial_q ? mask_q : '1;
    nxt   = '0;
    found = 1'b0;
    more  = 1'b0;
    for (int i = 0; i < NumDomains; i++) begin
      if (tgt[i] && (state_q != RELEASE || IdxW'(i) > idx_q)) begin
        if (found) begin
          more = 1'b1;
        end else begin
          nxt   = IdxW'(i);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    partial_d = partial_q;
    rst_n_d   = rst_n_q;
    all_rel_d = all_rel_q;
    cause_d   = cause_clr_i ? 4'b0000 : cause_q;
    if (full && state_q != ASSERT) begin
      state_d   = ASSERT;
      rst_n_d   = '0;
      all_rel_d = 1'b0;
      hold_d    = '0;
      gap_d     = '0;
      idx_d     = '0;
      mask_d    = '0;
      partial_d = 1'b0;
      if (!lock_s) cause_d[CausePll] = 1'b1;
      if (btn_db)  cause_d[CauseBtn] = 1'b1;
    end else begin
      case (state_q)
        ASSERT, PASSERT: begin
          if (full) begin
            hold_d = '0;
          end else if (hold_q == HoldLast) begin
            hold_d = '0;
            gap_d  = '0;
            idx_d  = nxt;
            if (found) rst_n_d[nxt] = 1'b1;
            if (more) begin
              state_d = RELEASE;
            end else begin
              state_d   = RUN;
              all_rel_d = 1'b1;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        RELEASE: begin
          if (gap_q == GapLast) begin
            gap_d = '0;
            idx_d = nxt;
            if (found) rst_n_d[nxt] = 1'b1;
            if (!more) begin
              state_d   = RUN;
              all_rel_d = 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        RUN: begin
          if (sw_rst_req_i && (|sw_rst_mask_i)) begin
            mask_d    = sw_rst_mask_i;
            partial_d = 1'b1;
            rst_n_d   = rst_n_q & ~sw_rst_mask_i;
            all_rel_d = 1'b0;
            hold_d    = '0;
            state_d   = PASSERT;
            cause_d[CauseSw] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ASSERT;
      hold_q    <= '0;
      gap_q     <= '0;
      idx_q     <= '0;
      mask_q    <= '0;
      partial_q <= 1'b0;
      rst_n_q   <= '0;
      all_rel_q <= 1'b0;
      cause_q   <= 4'b0001;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      partial_q <= partial_d;
      rst_n_q   <= rst_n_d;
      all_rel_q <= all_rel_d;
      cause_q   <= cause_d;
    end
  end

  assign rst_no         = rst_n_q;
  assign all_released_o = all_rel_q;
  assign rst_cause_o    = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboarded bench: each scenario queues the expected {all_released, rst_no} changes with their edge numbers.
module tb_rst_sequencer;

  localparam int N = 3;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         pll_locked_i = 1'b1;
  logic         rst_btn_i = 1'b0;
  logic         sw_rst_req_i = 1'b0;
  logic [N-1:0] sw_rst_mask_i = '0;
  logic         cause_clr_i = 1'b0;
  logic [N-1:0] rst_no;
  logic         all_released_o;
  logic [3:0]   rst_cause_o;

  rst_sequencer #(
    .NumDomains    (N),
    .HoldCycles    (4),
    .ReleaseGap    (2),
    .DebounceCycles(8)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pll_locked_i  (pll_locked_i),
    .rst_btn_i     (rst_btn_i),
    .sw_rst_req_i  (sw_rst_req_i),
    .sw_rst_mask_i (sw_rst_mask_i),
    .cause_clr_i   (cause_clr_i),
    .rst_no        (rst_no),
    .all_released_o(all_released_o),
    .rst_cause_o   (rst_cause_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         cyc;
    logic [N:0] val;
  } ev_t;

  ev_t        exp_q[$];
  logic [N:0] last_val = '0;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  // Edge 1 is the first rising edge after rst_i is released.
  always @(posedge clk_i) begin
    if (rst_i) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk_i) begin
    logic [N:0] cur;
    ev_t        e;
    cur = {all_released_o, rst_no};
    if (cur !== last_val) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected cyc=%0d got=%b required no change from %b", cyc, cur, last_val);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.val !== cur) begin
          errors++;
          $display("FAIL sb_event got cyc=%0d val=%b required cyc=%0d val=%b", cyc, cur, e.cyc, e.val);
        end
      end
      last_val = cur;
    end
  end

  task automatic push(input int c, input logic [N:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    checks++;
    if (rst_no !== 3'b000) begin
      errors++; $display("FAIL reset_rst_no got=%b required=000", rst_no);
    end
    checks++;
    if (all_released_o !== 1'b0) begin
      errors++; $display("FAIL reset_all_rel got=%b required=0", all_released_o);
    end
    checks++;
    if (rst_cause_o !== 4'b0001) begin
      errors++; $display("FAIL reset_cause got=%b required=0001", rst_cause_o);
    end
  endtask

  task automatic test_por();
    push(6, 4'b0001);
    push(8, 4'b0011);
    push(10, 4'b1111);
    rst_i = 1'b0;
    wait_until(12);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL por_missing got=%0d pending required=0", exp_q.size()); exp_q.delete();
    end
    checks++;
    if (rst_cause_o !== 4'b0001) begin
      errors++; $display("FAIL por_cause got=%b required=0001", rst_cause_o);
    end
  endtask

  task automatic test_partial();
    int k = cyc;
    cause_clr_i = 1'b1;
    wait_until(k + 1);
    cause_clr_i = 1'b0;
    sw_rst_req_i = 1'b1;
    sw_rst_mask_i = 3'b101;
    push(k + 2, 4'b0010);
    push(k + 6, 4'b0011);
    push(k + 8, 4'b1111);
    wait_until(k + 2);
    sw_rst_req_i = 1'b0;
    sw_rst_mask_i = '0;
    wait_until(k + 10);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL partial_missing got=%0d pending required=0", exp_q.size()); exp_q.delete();
    end
    checks++;
    if (rst_cause_o !== 4'b1000) begin
      errors++; $display("FAIL partial_cause got=%b required=1000", rst_cause_o);
    end
  endtask

  task automatic test_ignored();
    int k = cyc;
    cause_clr_i = 1'b1;
    wait_until(k + 1);
    cause_clr_i = 1'b0;
    sw_rst_req_i = 1'b1;
    sw_rst_mask_i = 3'b000;
    wait_until(k + 2);
    sw_rst_req_i = 1'b0;
    checks++;
    if (rst_cause_o !== 4'b0000) begin
      errors++; $display("FAIL ignored_mask0_cause got=%b required=0000", rst_cause_o);
    end
    wait_until(k + 3);
    sw_rst_req_i = 1'b1;
    sw_rst_mask_i = 3'b011;
    push(k + 4, 4'b0100);
    push(k + 8, 4'b0101);
    push(k + 10, 4'b1111);
    wait_until(k + 4);
    sw_rst_req_i = 1'b0;
    sw_rst_mask_i = '0;
    wait_until(k + 7);
    cause_clr_i = 1'b1;
    wait_until(k + 8);
    cause_clr_i = 1'b0;
    sw_rst_req_i = 1'b1;
    sw_rst_mask_i = 3'b100;
    wait_until(k + 9);
    sw_rst_req_i = 1'b0;
    sw_rst_mask_i = '0;
    wait_until(k + 12);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL ignored_missing got=%0d pending required=0", exp_q.size()); exp_q.delete();
    end
    checks++;
    if (rst_cause_o !== 4'b0000) begin
      errors++; $display("FAIL ignored_release_cause got=%b required=0000", rst_cause_o);
    end
  endtask

  task automatic test_clear_collision();
    int k = cyc;
    cause_clr_i = 1'b1;
    sw_rst_req_i = 1'b1;
    sw_rst_mask_i = 3'b001;
    push(k + 1, 4'b0110);
    push(k + 5, 4'b1111);
    wait_until(k + 1);
    cause_clr_i = 1'b0;
    sw_rst_req_i = 1'b0;
    sw_rst_mask_i = '0;
    checks++;
    if (rst_cause_o !== 4'b1000) begin
      errors++; $display("FAIL collision_cause got=%b required=1000", rst_cause_o);
    end
    wait_until(k + 8);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL collision_missing got=%0d pending required=0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_pll_loss();
    int k = cyc;
    cause_clr_i = 1'b1;
    pll_locked_i = 1'b0;
    push(k + 3, 4'b0000);
    push(k + 11, 4'b0001);
    push(k + 13, 4'b0011);
    push(k + 14, 4'b0000);
    push(k + 22, 4'b0001);
    push(k + 24, 4'b0011);
    push(k + 26, 4'b1111);
    wait_until(k + 1);
    cause_clr_i = 1'b0;
    checks++;
    if (rst_cause_o !== 4'b0000) begin
      errors++; $display("FAIL pll_clear_cause got=%b required=0000", rst_cause_o);
    end
    wait_until(k + 5);
    pll_locked_i = 1'b1;
    wait_until(k + 11);
    pll_locked_i = 1'b0;
    wait_until(k + 16);
    pll_locked_i = 1'b1;
    wait_until(k + 28);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pll_missing got=%0d pending required=0", exp_q.size()); exp_q.delete();
    end
    checks++;
    if (rst_cause_o !== 4'b0010) begin
      errors++; $display("FAIL pll_cause got=%b required=0010", rst_cause_o);
    end
  endtask

  task automatic test_button();
    int k = cyc;
    cause_clr_i = 1'b1;
    rst_btn_i = 1'b1;
    wait_until(k + 1);
    cause_clr_i = 1'b0;
    wait_until(k + 5);
    rst_btn_i = 1'b0;
    wait_until(k + 14);
    checks++;
    if (rst_cause_o !== 4'b0000) begin
      errors++; $display("FAIL btn_glitch_cause got=%b required=0000", rst_cause_o);
    end
    push(k + 26, 4'b0000);
    push(k + 49, 4'b0001);
    push(k + 51, 4'b0011);
    push(k + 53, 4'b1111);
    wait_until(k + 15);
    rst_btn_i = 1'b1;
    wait_until(k + 35);
    rst_btn_i = 1'b0;
    wait_until(k + 56);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL btn_missing got=%0d pending required=0", exp_q.size()); exp_q.delete();
    end
    checks++;
    if (rst_cause_o !== 4'b0100) begin
      errors++; $display("FAIL btn_cause got=%b required=0100", rst_cause_o);
    end
  endtask

  initial begin
    test_reset();
    test_por();
    test_partial();
    test_ignored();
    test_clear_collision();
    test_pll_loss();
    test_button();
    repeat (2) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
